ps2_note_scheduler: RTL and testbench

- Sits between the PS/2 byte receiver and the melody tone generator.
- Parses PS/2 scan-code bytes (make, break and extended prefixes) and queues accepted make codes in a FIFO.
- Replays each queued code on note_code for a fixed note time, followed by a fixed silent gap.
- Queued notes therefore play one after another, never overlapping and never cut short.

---
 rtl/ps2_note_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_note_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_note_scheduler.sv
// PS/2 scan-code parser feeding a note FIFO that replays make codes as fixed-length notes with gaps.
// Optional REPEAT_FILTER_EN drops typematic repeats of a held key.
module ps2_note_scheduler #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned NOTE_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 2500000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_valid,
  input  logic [7:0]               key_byte,
  input  logic                     flush,
  input  logic                     clr_ovf,
  output logic [7:0]               note_code,
  output logic                     playing,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {P_NORM, P_BRK, P_EXT, P_EXTBRK} pstate_e;
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} sstate_e;

  pstate_e            pstate_q, pstate_d;
  sstate_e            state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         note_q, note_d;
  logic               playing_q, playing_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic [FCNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]         mem_q [DEPTH];

  logic make_c, brk_c, accept_c, pop_c, push_c, full_c;

  // Scan-code parser: classifies each received byte
  always_comb begin
    pstate_d = pstate_q;
    make_c   = 1'b0;
    brk_c    = 1'b0;
    if (key_valid) begin
      unique case (pstate_q)
        P_NORM: begin
          if (key_byte == 8'hF0)      pstate_d = P_BRK;
          else if (key_byte == 8'hE0) pstate_d = P_EXT;
          else if (key_byte != 8'h00) make_c = 1'b1;
        end
        P_BRK: begin
          pstate_d = P_NORM;
          brk_c    = 1'b1;
        end
        P_EXT:    pstate_d = (key_byte == 8'hF0) ? P_EXTBRK : P_NORM;
        P_EXTBRK: begin
          pstate_d = P_NORM;
          brk_c    = 1'b1;
        end
        default:  pstate_d = P_NORM;
      endcase
    end
  end

`ifdef REPEAT_FILTER_EN
  logic       held_q, held_d;
  logic [7:0] last_make_q, last_make_d;

  // A make matching the still-held key is a typematic repeat
  always_comb begin
    accept_c    = make_c && !(held_q && (key_byte == last_make_q));
    held_d      = held_q;
    last_make_d = last_make_q;
    if (flush) begin
      held_d = 1'b0;
    end else if (accept_c) begin
      held_d      = 1'b1;
      last_make_d = key_byte;
    end else if (brk_c) begin
      held_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q      <= 1'b0;
      last_make_q <= 8'h00;
    end else begin
      held_q      <= held_d;
      last_make_q <= last_make_d;
    end
  end
`else
  always_comb accept_c = make_c;
`endif

  // Note sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    pop_c   = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      note_d  = 8'h00;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_d = S_PLAY;
            note_d  = mem_q[rd_ptr_q];
            pop_c   = 1'b1;
            cnt_d   = CNT_W'(NOTE_CYCLES - 1);
          end
        end
        S_PLAY: begin
          if (cnt_q == '0) begin
            state_d = S_GAP;
            note_d  = 8'h00;
            cnt_d   = CNT_W'(GAP_CYCLES - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (count_q != '0) begin
            state_d = S_PLAY;
            note_d  = mem_q[rd_ptr_q];
            pop_c   = 1'b1;
            cnt_d   = CNT_W'(NOTE_CYCLES - 1);
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          note_d  = 8'h00;
        end
      endcase
    end
  end

  // FIFO bookkeeping; a pop on the same edge frees a slot for a push
  always_comb begin
    full_c   = (count_q == FCNT_W'(DEPTH));
    push_c   = accept_c && !flush && (!full_c || pop_c);
    ovf_d    = (ovf_q && !clr_ovf) || (accept_c && !flush && full_c && !pop_c);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      count_d = count_q + FCNT_W'(1);
      else if (pop_c && !push_c) count_d = count_q - FCNT_W'(1);
    end
    playing_d = (state_d == S_PLAY);
    busy_d    = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate_q  <= P_NORM;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      note_q    <= 8'h00;
      playing_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      pstate_q  <= pstate_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      note_q    <= note_d;
      playing_q <= playing_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= key_byte;
  end

  assign note_code  = note_q;
  assign playing    = playing_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_note_scheduler.sv
// Randomized bench for ps2_note_scheduler against a timestamp-based scheduling model.
module tb_ps2_note_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NOTE  = 4;
  localparam int unsigned GAP   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_byte = 8'h00;
  logic       flush = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] note_code;
  logic       playing, busy, overflow;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fails  = 0;

  ps2_note_scheduler #(.DEPTH(DEPTH), .NOTE_CYCLES(NOTE), .GAP_CYCLES(GAP), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_byte(key_byte),
    .flush(flush), .clr_ovf(clr_ovf), .note_code(note_code), .playing(playing),
    .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: queue of codes plus the edge timestamps of the current note
  logic [7:0] m_q[$];
  int         m_e, m_free_at, m_note_end;
  logic [7:0] m_cur;
  logic       m_ovf, m_held;
  logic [7:0] m_last;
  int         m_ps;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, m_e);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_e = 0; m_free_at = 0; m_note_end = 0; m_cur = 8'h00;
    m_ovf = 1'b0; m_held = 1'b0; m_last = 8'h00; m_ps = 0;
  endtask

  task automatic model_edge(input logic kv, input logic [7:0] kb, input logic fl, input logic co);
    logic is_make, is_brk, accept;
    int   sz, popped;
    m_e++;
    is_make = 1'b0; is_brk = 1'b0;
    if (kv) begin
      case (m_ps)
        0: if (kb == 8'hF0) m_ps = 1; else if (kb == 8'hE0) m_ps = 2; else if (kb != 8'h00) is_make = 1'b1;
        1: begin m_ps = 0; is_brk = 1'b1; end
        2: m_ps = (kb == 8'hF0) ? 3 : 0;
        default: begin m_ps = 0; is_brk = 1'b1; end
      endcase
    end
    accept = is_make;
`ifdef REPEAT_FILTER_EN
    if (is_make && m_held && kb == m_last) accept = 1'b0;
    if (fl) m_held = 1'b0;
    else if (accept) begin m_held = 1'b1; m_last = kb; end
    else if (is_brk) m_held = 1'b0;
`endif
    if (co) m_ovf = 1'b0;
    if (fl) begin
      m_q.delete();
      m_free_at = m_e; m_note_end = m_e; m_cur = 8'h00;
    end else begin
      sz = m_q.size(); popped = 0;
      if (m_e >= m_free_at && sz > 0) begin
        m_cur = m_q.pop_front();
        m_note_end = m_e + NOTE;
        m_free_at  = m_e + NOTE + GAP;
        popped = 1;
      end
      if (accept) begin
        if (sz - popped < DEPTH) m_q.push_back(kb);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("note_code",  32'(note_code),  32'((m_e < m_note_end) ? m_cur : 8'h00));
    check_eq("playing",    32'(playing),    32'(m_e < m_note_end));
    check_eq("busy",       32'(busy),       32'((m_e < m_free_at) || (m_q.size() != 0)));
    check_eq("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check_eq("overflow",   32'(overflow),   32'(m_ovf));
  endtask

  task automatic step(input logic kv, input logic [7:0] kb, input logic fl, input logic co);
    key_valid = kv; key_byte = kb; flush = fl; clr_ovf = co;
    @(posedge clk);
    model_edge(kv, kb, fl, co);
    #1;
    compare_all();
    key_valid = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [7:0] b, input int gap_after);
    step(1'b1, b, 1'b0, 1'b0);
    idle(gap_after);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_note"}, 32'(note_code), 32'h0);
    check_eq({tag, "_play"}, 32'(playing), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_cnt"},  32'(fifo_count), 32'h0);
    check_eq({tag, "_ovf"},  32'(overflow), 32'h0);
  endtask

  logic [7:0] pick[7];
  logic [7:0] ov_seq[6];
  logic [7:0] rep_seq[6];

  initial begin
    pick = '{8'hF0, 8'hE0, 8'h00, 8'h1C, 8'h1B, 8'h23, 8'h15};
    ov_seq = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
    rep_seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // single key with release
    key(8'h1C, 2); key(8'hF0, 2); key(8'h1C, 2);
    idle(10);

    // back-to-back notes
    key(8'h1C, 1); key(8'h1B, 1); key(8'h23, 1);
    idle(22);

    // overflow and clear
    for (int i = 0; i < 6; i++) step(1'b1, ov_seq[i], 1'b0, 1'b0);
    check_eq("ovf_peak_count", 32'(fifo_count), 32'd4);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("ovf_cleared", 32'(overflow), 32'd0);
    idle(40);

    // extended and zero bytes push nothing; parser back in normal mode
    key(8'hE0, 0); key(8'h75, 0); key(8'hE0, 0); key(8'hF0, 0); key(8'h75, 0); key(8'h00, 1);
    check_eq("ext_no_push", 32'(fifo_count), 32'd0);
    key(8'h29, 1);
    check_eq("parser_norm", 32'(note_code), 32'h29);
    idle(8);

    // flush during a note with two queued
    key(8'h1C, 0); key(8'h1B, 0); key(8'h23, 1);
    check_eq("flush_pre_count", 32'(fifo_count), 32'd2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("flush_note", 32'(note_code), 32'h0);
    check_eq("flush_count", 32'(fifo_count), 32'd0);
    idle(3);

    // typematic repeat stream
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, rep_seq[i], 1'b0, 1'b0);
`ifdef REPEAT_FILTER_EN
    check_eq("repeat_count", 32'(fifo_count), 32'd1);
`else
    check_eq("repeat_count", 32'(fifo_count), 32'd3);
`endif
    idle(40);

    // asynchronous reset in the middle of a gap
    key(8'h34, 0);
    for (int i = 0; i < 30 && !(m_e >= m_note_end && m_e < m_free_at); i++) idle(1);
    check_eq("gap_reached", 32'(m_e >= m_note_end && m_e < m_free_at), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      logic kv, fl, co;
      logic [7:0] b;
      kv = ($urandom_range(0, 99) < 40);
      fl = ($urandom_range(0, 99) == 0);
      co = ($urandom_range(0, 49) == 0);
      b  = ($urandom_range(0, 7) == 7) ? 8'($urandom) : pick[$urandom_range(0, 6)];
      step(kv, b, fl, co);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
